// File: rtl/pla_eval_pipe.sv
// Runtime-programmable sum-of-products evaluator. A 2-stage valid/ready pipeline
// carries input vectors through a loadable AND-plane (cube table) and OR-plane.

module pla_term #(
  parameter int N_IN = 8
) (
  input  logic [N_IN-1:0] x,
  input  logic [N_IN-1:0] care,
  input  logic [N_IN-1:0] val,
  input  logic            en,
  output logic            match
);
  assign match = en & ~|((x ^ val) & care);
endmodule

module pla_eval_pipe #(
  parameter int               N_IN    = 8,
  parameter int               N_OUT   = 1,
  parameter int               N_TERMS = 16,
  parameter logic [N_OUT-1:0] OUT_INV = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [N_IN-1:0]            in_x,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [N_OUT-1:0]           out_y,
  input  logic                       out_ready,
  input  logic                       prog_we,
  input  logic [$clog2(N_TERMS)-1:0] prog_addr,
  input  logic [N_IN-1:0]            prog_care,
  input  logic [N_IN-1:0]            prog_val,
  input  logic [N_OUT-1:0]           prog_omask,
  input  logic                       prog_clr,
  output logic                       prog_ready
);
  logic [N_TERMS-1:0][N_IN-1:0]  care_q, val_q;
  logic [N_TERMS-1:0][N_OUT-1:0] omask_q;
  logic [N_TERMS-1:0]            en_q, en_nxt, match;
  logic                          v1, v2;
  logic [N_IN-1:0]               x1;
  logic [N_OUT-1:0]              y2, or_y, y_comb;
  logic                          s2_load, s1_adv, acc, wr, clr;

  assign s2_load    = !v2 | out_ready;
  assign s1_adv     = v1 & s2_load;
  assign in_ready   = (!v1 | s1_adv) & !(prog_we | prog_clr);
  assign acc        = in_valid & in_ready;
  assign prog_ready = !v1 & !v2;
  assign wr         = prog_we & prog_ready;
  assign clr        = prog_clr & prog_ready;
  assign out_valid  = v2;
  assign out_y      = y2;

  // Cube storage is qualified by en_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr) begin
      care_q[prog_addr]  <= prog_care;
      val_q[prog_addr]   <= prog_val;
      omask_q[prog_addr] <= prog_omask;
    end
  end

  // Clear first, then the write lands, so clr+we leaves exactly one live term.
  always_comb begin
    en_nxt = clr ? '0 : en_q;
    if (wr) en_nxt[prog_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_q <= '0;
    else        en_q <= en_nxt;
  end

  for (genvar t = 0; t < N_TERMS; t++) begin : g_term
    pla_term #(.N_IN(N_IN)) u_term (
      .x    (x1),
      .care (care_q[t]),
      .val  (val_q[t]),
      .en   (en_q[t]),
      .match(match[t])
    );
  end

  always_comb begin
    or_y = '0;
    for (int t = 0; t < N_TERMS; t++) or_y |= omask_q[t] & {N_OUT{match[t]}};
    y_comb = or_y ^ OUT_INV;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      x1 <= '0;
      v2 <= 1'b0;
      y2 <= '0;
    end else begin
      if (acc) begin
        v1 <= 1'b1;
        x1 <= in_x;
      end else if (s1_adv) begin
        v1 <= 1'b0;
      end
      if (s2_load) begin
        v2 <= v1;
        if (v1) y2 <= y_comb;
      end
    end
  end
endmodule

// File: tb/tb_pla_eval_pipe.sv
// Directed bench for pla_eval_pipe with N_OUT=2, OUT_INV=2'b10; expected values hand-derived.
module tb_pla_eval_pipe;
  localparam int N_IN = 8, N_OUT = 2, N_TERMS = 16;
  localparam logic [N_OUT-1:0] INV = 2'b10;

  logic              clk = 1'b0;
  logic              rst_n, in_valid, in_ready, out_valid, out_ready;
  logic              prog_we, prog_clr, prog_ready;
  logic [N_IN-1:0]   in_x, prog_care, prog_val;
  logic [N_OUT-1:0]  out_y, prog_omask;
  logic [3:0]        prog_addr;

  int total = 0, bad = 0;

  logic [7:0] vec [8] = '{8'h00, 8'h33, 8'h7E, 8'hC1, 8'h03, 8'hFE, 8'h80, 8'h55};
  logic [1:0] ex  [8] = '{2'b11, 2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b11, 2'b10};

  pla_eval_pipe #(.N_IN(N_IN), .N_OUT(N_OUT), .N_TERMS(N_TERMS), .OUT_INV(INV)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_x(in_x), .in_ready(in_ready),
    .out_valid(out_valid), .out_y(out_y), .out_ready(out_ready),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_care(prog_care), .prog_val(prog_val),
    .prog_omask(prog_omask), .prog_clr(prog_clr), .prog_ready(prog_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic prog(input logic c, input logic w, input logic [3:0] a,
                      input logic [7:0] care, input logic [7:0] v, input logic [1:0] om);
    @(negedge clk);
    prog_clr = c; prog_we = w; prog_addr = a;
    prog_care = care; prog_val = v; prog_omask = om;
    #1;
    chk("prog_rdy", 32'(prog_ready), 1);
    chk("prog_in_rdy", 32'(in_ready), 0);
    @(negedge clk);
    prog_clr = 1'b0; prog_we = 1'b0;
  endtask

  task automatic run1(input string tag, input logic [7:0] x, input logic [1:0] exp);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_x = x; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_vld"}, 32'(out_valid), 1);
    chk(tag, 32'(out_y), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int tx, rx;
    logic [1:0] held;
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
    prog_we = 1'b0; prog_clr = 1'b0; prog_addr = '0;
    prog_care = '0; prog_val = '0; prog_omask = '0;
    held = '0;
    #12;
    chk("rst_ovld", 32'(out_valid), 0);
    chk("rst_oy", 32'(out_y), 0);
    chk("rst_inrdy", 32'(in_ready), 1);
    chk("rst_prdy", 32'(prog_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // empty table, tautology term, clear
    run1("empty", 8'h5A, 2'b10);
    prog(1'b0, 1'b1, 4'd5, 8'h00, 8'h00, 2'b11);
    run1("taut", 8'h5A, 2'b01);
    prog(1'b1, 1'b0, 4'd0, 8'h00, 8'h00, 2'b00);
    run1("clr", 8'h5A, 2'b10);

    // term 0: x0 == 0 -> y[0]; three back-to-back vectors
    prog(1'b0, 1'b1, 4'd0, 8'h01, 8'h00, 2'b01);
    @(negedge clk);
    in_valid = 1'b1; in_x = 8'h00; out_ready = 1'b1;
    #1 chk("s_inrdy", 32'(in_ready), 1);
    @(negedge clk);
    chk("s_lat", 32'(out_valid), 0);
    in_x = 8'h01;
    @(negedge clk);
    chk("s0_vld", 32'(out_valid), 1);
    chk("s0_y", 32'(out_y), 2'b11);
    in_x = 8'hFE;
    @(negedge clk);
    chk("s1_y", 32'(out_y), 2'b10);
    in_valid = 1'b0;
    @(negedge clk);
    chk("s2_vld", 32'(out_valid), 1);
    chk("s2_y", 32'(out_y), 2'b11);
    chk("s2_prdy", 32'(prog_ready), 0);
    @(negedge clk);
    chk("s_drain", 32'(out_valid), 0);
    chk("s_prdy_rise", 32'(prog_ready), 1);

    // 8-vector stream with a 3-cycle consumer stall
    tx = 0; rx = 0;
    for (int cyc = 0; cyc < 40 && rx < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc <= 6);
      in_valid = (tx < 8);
      if (tx < 8) in_x = vec[tx];
      #1;
      if (cyc == 4) held = out_y;
      if (cyc >= 4 && cyc <= 6) begin
        chk("stall_vld", 32'(out_valid), 1);
        chk("stall_inrdy", 32'(in_ready), 0);
        chk("stall_y", 32'(out_y), 32'(ex[rx]));
      end
      if (cyc == 5 || cyc == 6) chk("stall_hold", 32'(out_y), 32'(held));
      if (out_valid && out_ready) begin
        chk("strm_y", 32'(out_y), 32'(ex[rx]));
        rx++;
      end
      if (in_valid && in_ready) tx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("strm_rx", 32'(rx), 8);
    chk("strm_tx", 32'(tx), 8);

    // programming while busy is refused
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1; in_x = 8'h01;
    @(negedge clk);
    in_valid = 1'b0;
    prog_we = 1'b1; prog_addr = 4'd1; prog_care = 8'h00; prog_val = 8'h00; prog_omask = 2'b01;
    #1;
    chk("busy_prdy", 32'(prog_ready), 0);
    chk("busy_inrdy", 32'(in_ready), 0);
    @(negedge clk);
    prog_we = 1'b0;
    chk("busy_fly_vld", 32'(out_valid), 1);
    chk("busy_fly_y", 32'(out_y), 2'b10);
    run1("busy_tbl", 8'h01, 2'b10);
    prog(1'b0, 1'b1, 4'd1, 8'h00, 8'h00, 2'b01);
    run1("retry", 8'h01, 2'b11);

    // clear + write in one cycle
    prog(1'b1, 1'b0, 4'd0, 8'h00, 8'h00, 2'b00);
    prog(1'b0, 1'b1, 4'd0, 8'hFF, 8'h00, 2'b01);
    prog(1'b0, 1'b1, 4'd1, 8'hFF, 8'h11, 2'b01);
    prog(1'b0, 1'b1, 4'd2, 8'hFF, 8'h22, 2'b01);
    prog(1'b0, 1'b1, 4'd3, 8'hFF, 8'h33, 2'b01);
    run1("t4_11", 8'h11, 2'b11);
    prog(1'b1, 1'b1, 4'd3, 8'hFF, 8'h33, 2'b01);
    run1("cw_11", 8'h11, 2'b10);
    run1("cw_33", 8'h33, 2'b11);
    run1("cw_00", 8'h00, 2'b10);

    // reset with two vectors in flight
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1; in_x = 8'h33; out_ready = 1'b0;
    @(negedge clk);
    in_x = 8'h00;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_pre_vld", 32'(out_valid), 1);
    chk("rst_pre_prdy", 32'(prog_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_vld", 32'(out_valid), 0);
    chk("rst_async_y", 32'(out_y), 0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    run1("rst_tbl", 8'h33, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
